// File: rtl/axi_user_arbiter.sv
// Round-robin arbiter sharing one m_axi_ctrl wr_*/rd_* user port pair among NUM_REQ requesters.
// Optional watchdog enabled by defining AXI_ARB_TIMEOUT_EN.
module axi_user_arbiter #(
  parameter int unsigned  NUM_REQ     = 4,
  parameter int unsigned  ADDR_W      = 32,
  parameter int unsigned  DATA_W      = 32,
  parameter int unsigned  TIMEOUT_CYC = 4096,
  localparam int unsigned IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_vld,
  input  logic [NUM_REQ-1:0]          req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*8-1:0]        req_len,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic [NUM_REQ-1:0]          req_wready,
  output logic [DATA_W-1:0]           req_rdata,
  output logic [NUM_REQ-1:0]          req_rvld,
  output logic [NUM_REQ-1:0]          req_done,
  output logic                        busy,
  output logic [IDX_W-1:0]            grant_idx,
  output logic                        err,
  output logic                        wr_start,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [7:0]                  wr_len,
  output logic [DATA_W-1:0]           wr_data,
  input  logic                        wr_ready,
  input  logic                        wr_done,
  output logic                        rd_start,
  output logic [ADDR_W-1:0]           rd_addr,
  output logic [7:0]                  rd_len,
  input  logic [DATA_W-1:0]           rd_data,
  input  logic                        rd_vld,
  input  logic                        rd_done
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StIssue  = 3'd1;
  localparam logic [2:0] StWrBusy = 3'd2;
  localparam logic [2:0] StRdBusy = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic              wr_q, wr_d;
  logic              wr_start_q, wr_start_d;
  logic              rd_start_q, rd_start_d;

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [7:0]        len_arr   [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign len_arr[g]   = req_len[g*8 +: 8];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  // Search starts just after the last winner so the previous grantee has lowest priority.
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      if (!win_found && req_vld[IDX_W'((int'(ptr_q) + i) % int'(NUM_REQ))]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((int'(ptr_q) + i) % int'(NUM_REQ));
      end
    end
  end

  logic timeout;
  logic in_busy;
  assign in_busy = (state_q == StWrBusy) || (state_q == StRdBusy);

`ifdef AXI_ARB_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  assign timeout = (cnt_q == 32'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = in_busy ? cnt_q + 32'd1 : '0;
    err_d = err_q;
    if (state_q == StWrBusy && !wr_done && timeout) err_d = 1'b1;
    if (state_q == StRdBusy && !rd_done && timeout) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
  assign timeout    = 1'b0;
  assign err        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wr_d       = wr_q;
    wr_start_d = 1'b0;
    rd_start_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_d = win_idx;
          addr_d  = addr_arr[win_idx];
          len_d   = len_arr[win_idx];
          wr_d    = req_wr[win_idx];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (len_q == '0) begin
          state_d = StDone;
        end else if (wr_q) begin
          wr_start_d = 1'b1;
          state_d    = StWrBusy;
        end else begin
          rd_start_d = 1'b1;
          state_d    = StRdBusy;
        end
      end
      StWrBusy: if (wr_done || timeout) state_d = StDone;
      StRdBusy: if (rd_done || timeout) state_d = StDone;
      StDone: begin
        ptr_d   = grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      grant_q    <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      wr_q       <= 1'b0;
      wr_start_q <= 1'b0;
      rd_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wr_q       <= wr_d;
      wr_start_q <= wr_start_d;
      rd_start_q <= rd_start_d;
    end
  end

  // Data handshakes are steered only to the current grantee; everything else reads 0.
  always_comb begin
    req_ack    = '0;
    req_done   = '0;
    req_wready = '0;
    req_rvld   = '0;
    wr_data    = '0;
    req_rdata  = '0;
    case (state_q)
      StIssue:  req_ack[grant_q] = 1'b1;
      StWrBusy: begin
        req_wready[grant_q] = wr_ready;
        wr_data             = wdata_arr[grant_q];
      end
      StRdBusy: begin
        req_rvld[grant_q] = rd_vld;
        req_rdata         = rd_data;
      end
      StDone:   req_done[grant_q] = 1'b1;
      default: ;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign grant_idx = grant_q;
  assign wr_start  = wr_start_q;
  assign rd_start  = rd_start_q;
  assign wr_addr   = addr_q;
  assign rd_addr   = addr_q;
  assign wr_len    = len_q;
  assign rd_len    = len_q;

endmodule

// File: tb/tb_axi_user_arbiter.sv
// Self-checking bench for axi_user_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed latencies, grant orders and beat counts.
module tb_axi_user_arbiter;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_vld, req_wr;
  logic [N*32-1:0]   req_addr;
  logic [N*8-1:0]    req_len;
  logic [N*32-1:0]   req_wdata;
  logic [N-1:0]      req_ack, req_wready, req_rvld, req_done;
  logic [31:0]       req_rdata;
  logic              busy, err;
  logic [1:0]        grant_idx;
  logic              wr_start, rd_start;
  logic [31:0]       wr_addr, rd_addr, wr_data, rd_data;
  logic [7:0]        wr_len, rd_len;
  logic              wr_ready, wr_done, rd_vld, rd_done;

  axi_user_arbiter #(.NUM_REQ(N), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4096)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_wr(req_wr), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .req_ack(req_ack), .req_wready(req_wready),
    .req_rdata(req_rdata), .req_rvld(req_rvld), .req_done(req_done), .busy(busy),
    .grant_idx(grant_idx), .err(err), .wr_start(wr_start), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_data(wr_data), .wr_ready(wr_ready), .wr_done(wr_done), .rd_start(rd_start),
    .rd_addr(rd_addr), .rd_len(rd_len), .rd_data(rd_data), .rd_vld(rd_vld), .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nerr = 0;
  int nchk = 0;

  // Model state: 0 idle, 1 accepted, 2 burst in flight, 3 completing
  int          m_mode, m_g, m_ptr, m_age;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic        m_wr;

  // Observations for the directed checks
  int ack_cyc, done_cyc, wstart_cyc, wrdone_cyc, nstart, wbeat_ok0;
  int nack  [N];
  int rbeat [N];
  logic [31:0] rstart_addr;
  logic [7:0]  rstart_len;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic [N-1:0] e_ack, e_done, e_wr, e_rv;
    logic [31:0]  e_wd, e_rd;
    logic         e_wst, e_rst, found;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_mode = 0; m_ptr = N - 1; m_g = 0; m_addr = '0; m_len = '0; m_wr = 1'b0; m_age = 0;
        chk("reset wr addr/len", {wr_addr, wr_len}, '0);
        chk("reset rd addr/len", {rd_addr, rd_len}, '0);
      end
      e_ack = '0; e_done = '0; e_wr = '0; e_rv = '0; e_wd = '0; e_rd = '0;
      if (m_mode == 1) e_ack[m_g] = 1'b1;
      if (m_mode == 3) e_done[m_g] = 1'b1;
      if (m_mode == 2 && m_wr) begin
        e_wr[m_g] = wr_ready;
        e_wd      = req_wdata[m_g*32 +: 32];
      end
      if (m_mode == 2 && !m_wr) begin
        e_rv[m_g] = rd_vld;
        e_rd      = rd_data;
      end
      e_wst = (m_mode == 2) && (m_age == 0) && m_wr;
      e_rst = (m_mode == 2) && (m_age == 0) && !m_wr;
      chk("ctrl {busy,err,ack,done,wready,rvld,wst,rst,grant}",
          {busy, err, req_ack, req_done, req_wready, req_rvld, wr_start, rd_start, grant_idx},
          {m_mode != 0, 1'b0, e_ack, e_done, e_wr, e_rv, e_wst, e_rst, 2'(m_g)});
      chk("wr_data", wr_data, e_wd);
      chk("req_rdata", req_rdata, e_rd);
      if (e_wst) chk("wr addr/len at start", {wr_addr, wr_len}, {m_addr, m_len});
      if (e_rst) chk("rd addr/len at start", {rd_addr, rd_len}, {m_addr, m_len});

      if (req_ack != '0) ack_cyc = cyc;
      if (req_done != '0) done_cyc = cyc;
      if (wr_done) wrdone_cyc = cyc;
      if (wr_start) begin wstart_cyc = cyc; nstart++; end
      if (rd_start) begin nstart++; rstart_addr = rd_addr; rstart_len = rd_len; end
      if (req_wready[0] && wr_data == req_wdata[31:0]) wbeat_ok0++;
      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) nack[i]++;
        if (req_rvld[i]) rbeat[i]++;
      end

      if (rst_n) begin
        case (m_mode)
          0: begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
              int c;
              c = (m_ptr + k) % N;
              if (!found && req_vld[c]) begin found = 1'b1; m_g = c; end
            end
            if (found) begin
              m_addr = req_addr[m_g*32 +: 32];
              m_len  = req_len[m_g*8 +: 8];
              m_wr   = req_wr[m_g];
              m_mode = 1;
            end
          end
          1: begin
            m_mode = (m_len == 0) ? 3 : 2;
            m_age  = 0;
          end
          2: if (m_wr ? wr_done : rd_done) m_mode = 3; else m_age++;
          default: begin m_ptr = m_g; m_mode = 0; end
        endcase
      end
    end
  endtask

  // m_axi_ctrl stand-in: len beats, then done; injects one stray done of the other direction.
  initial begin
    wr_ready = 0; wr_done = 0; rd_vld = 0; rd_done = 0; rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (wr_start) begin
        for (int b = 0; b < int'(wr_len); b++) begin
          wr_ready = 1; rd_done = (b == 1);
          @(posedge clk); #1;
        end
        wr_ready = 0; rd_done = 0; wr_done = 1;
        @(posedge clk); #1;
        wr_done = 0;
      end else if (rd_start) begin
        for (int b = 0; b < int'(rd_len); b++) begin
          rd_vld = 1; rd_data = 32'hD000_0000 | 32'(b); wr_done = (b == 1);
          @(posedge clk); #1;
        end
        rd_vld = 0; wr_done = 0; rd_done = 1;
        @(posedge clk); #1;
        rd_done = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [7:0] l);
    req_wr[i]            = wr;
    req_addr[i*32 +: 32] = a;
    req_len[i*8 +: 8]    = l;
    req_wdata[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
  endtask

  task automatic wait_ack(output int idx);
    idx = -1;
    for (int n = 0; n < 80 && idx < 0; n++) begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) if (req_ack[k]) idx = k;
    end
    if (idx < 0) chk("ack within 80 cycles", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    bit seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(posedge clk); #1;
      if (!busy) seen = 1;
    end
    if (!seen) chk("idle within 200 cycles", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  int k, c0, snap, snap2;
  int order [5];
  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 0; req_vld = '0; req_wr = '0; req_addr = '0; req_len = '0; req_wdata = '0;
    nstart = 0; wbeat_ok0 = 0;
    for (int i = 0; i < N; i++) begin nack[i] = 0; rbeat[i] = 0; end
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy/err/grant", {busy, err, grant_idx}, '0);
    chk("reset handshakes", {req_ack, req_done, req_wready, req_rvld, wr_start, rd_start}, '0);
    rst_n = 1;

    // Single write from requester 0
    @(posedge clk); #1;
    set_req(0, 1'b1, 32'h0100_0000, 8'd16);
    snap = wbeat_ok0; c0 = cyc; req_vld[0] = 1;
    wait_ack(k); req_vld[0] = 0;
    chk("write grant", k, 0);
    wait_idle();
    chk("write ack latency", ack_cyc - c0, 1);
    chk("write start latency", wstart_cyc - c0, 2);
    chk("wr_done to req_done", done_cyc - wrdone_cyc, 1);
    chk("write beats of req0 data", wbeat_ok0 - snap, 16);

    // Contention from a fresh reset; requester 0 stays raised through its own burst
    do_reset();
    set_req(0, 1'b1, 32'h0000_1000, 8'd4);
    set_req(1, 1'b0, 32'h0000_2000, 8'd4);
    set_req(2, 1'b1, 32'h0000_3000, 8'd4);
    set_req(3, 1'b0, 32'h0000_4000, 8'd4);
    req_vld = 4'hF;
    for (int j = 0; j < 5; j++) begin
      wait_ack(k);
      order[j] = k;
      if (k >= 0 && !(k == 0 && j == 0)) req_vld[k] = 0;
    end
    req_vld = '0;
    wait_idle();
    for (int j = 0; j < 5; j++) chk($sformatf("contention grant %0d", j), order[j], exp_order[j]);

    // Read steering to requester 2
    set_req(2, 1'b0, 32'h0100_0040, 8'd16);
    snap = rbeat[2]; snap2 = rbeat[0] + rbeat[1] + rbeat[3];
    req_vld[2] = 1;
    wait_ack(k); req_vld[2] = 0;
    chk("read grant", k, 2);
    wait_idle();
    chk("read beats on req2", rbeat[2] - snap, 16);
    chk("read beats elsewhere", rbeat[0] + rbeat[1] + rbeat[3] - snap2, 0);
    chk("read start addr/len", {rstart_addr, rstart_len}, {32'h0100_0040, 8'd16});

    // Zero-length request: no AXI start
    @(posedge clk); #1;
    set_req(1, 1'b1, 32'h0000_5000, 8'd0);
    snap = nstart; c0 = cyc; req_vld[1] = 1;
    wait_ack(k); req_vld[1] = 0;
    chk("len0 grant", k, 1);
    wait_idle();
    chk("len0 ack latency", ack_cyc - c0, 1);
    chk("len0 done latency", done_cyc - c0, 2);
    chk("len0 no start", nstart - snap, 0);

    // Pointer wrap: after requester 3, 0 beats 2
    set_req(3, 1'b0, 32'h0000_6000, 8'd2);
    req_vld[3] = 1;
    wait_ack(k); req_vld[3] = 0;
    wait_idle();
    set_req(0, 1'b1, 32'h0000_7000, 8'd2);
    set_req(2, 1'b0, 32'h0000_7100, 8'd2);
    req_vld = 4'b0101;
    wait_ack(k); req_vld[0] = 0;
    chk("wrap first grant", k, 0);
    wait_ack(k); req_vld[2] = 0;
    chk("wrap second grant", k, 2);
    wait_idle();

    // Request withdrawn before acceptance is never granted
    set_req(0, 1'b1, 32'h0000_8000, 8'd8);
    req_vld[0] = 1;
    wait_ack(k); req_vld[0] = 0;
    snap = nack[1];
    req_vld[1] = 1;
    repeat (3) @(posedge clk);
    #1 req_vld[1] = 0;
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    chk("withdrawn request not acked", nack[1] - snap, 0);

    // Reset mid-burst; the slave's late wr_done lands while idle
    set_req(2, 1'b1, 32'h0000_9000, 8'd16);
    req_vld[2] = 1;
    wait_ack(k); req_vld[2] = 0;
    repeat (5) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1;
    chk("busy in reset", busy, 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (25) @(posedge clk);
    #1;
    chk("idle after stray done", {busy, req_done}, '0);
    set_req(1, 1'b1, 32'h0000_A000, 8'd2);
    req_vld[1] = 1;
    wait_ack(k); req_vld[1] = 0;
    chk("grant after reset", k, 1);
    wait_idle();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
